// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line scheduler.
// Includes the scheduler FSM states and the ROM address packing function.
package sprite_pkg;

   localparam int NUM_SPR = 4;
   localparam int SPR_H   = 32;
   localparam int SPR_W   = 16;
   localparam int V_TOTAL = 525;
   localparam int Y_W     = 10;
   localparam int IMG_W   = 2;
   localparam int ROW_W   = 5;
   localparam int ADDR_W  = IMG_W + ROW_W;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      REQ,
      WAIT,
      COMMIT,
      DRAIN
   } state_e;

   function automatic logic [ADDR_W-1:0] pack_rom_addr(input logic [IMG_W-1:0] img,
                                                      input logic [ROW_W-1:0] row);
      return {img, row};
   endfunction

endpackage

// File: rtl/hs_edge_detect.sv
// Registered falling-edge detector for horizontal sync.
// The pulse appears one cycle after the low level is first sampled.
module hs_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic hs,
   output logic hs_fall
);

   logic hs_q;
   logic hs_qq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q  <= 1'b1;
         hs_qq <= 1'b1;
      end else begin
         hs_q  <= hs;
         hs_qq <= hs_q;
      end
   end

   assign hs_fall = hs_qq & ~hs_q;

endmodule

// File: rtl/sprite_line_scheduler.sv
// Fetches one ROM row per visible sprite for the next scanline into shadow
// buffers, then commits them to the active RowMask/RowValid in one cycle.
module sprite_line_scheduler #(
   parameter int NUM_SPR = sprite_pkg::NUM_SPR,
   parameter int SPR_H   = sprite_pkg::SPR_H,
   parameter int SPR_W   = sprite_pkg::SPR_W,
   parameter int V_TOTAL = sprite_pkg::V_TOTAL
) (
   input  logic                           Clk,
   input  logic                           Reset_n,
   input  logic                           VGA_HS,
   input  logic [9:0]                     DrawY,
   input  logic [NUM_SPR-1:0][9:0]        SpriteX,
   input  logic [NUM_SPR-1:0][9:0]        SpriteY,
   input  logic [NUM_SPR-1:0]             SpriteEn,
   input  logic [NUM_SPR-1:0][1:0]        SpriteImg,
   output logic                           rom_req,
   output logic [6:0]                     rom_addr,
   input  logic                           rom_ack,
   input  logic [SPR_W-1:0]               rom_data,
   output logic [NUM_SPR-1:0][SPR_W-1:0]  RowMask,
   output logic [NUM_SPR-1:0]             RowValid,
   output logic                           line_ready,
   output logic                           overrun
);

   import sprite_pkg::*;

   localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

   state_e                         state, state_nxt;
   logic                           hs_fall;
   logic [IDX_W-1:0]               idx;
   logic [9:0]                     next_y, next_y_calc;
   logic [NUM_SPR-1:0][9:0]        diff;
   logic [NUM_SPR-1:0]             hit_vec;
   logic [NUM_SPR-1:0][SPR_W-1:0]  shadow;
   logic [NUM_SPR-1:0]             shadow_vld;
   logic                           hit, last;
   logic                           latch_y, restart, idx_inc, req_load, req_clr;
   logic                           ack_store, commit, set_ovr;

   // X position only matters to the pixel pipeline downstream.
   logic unused_spritex;
   assign unused_spritex = ^SpriteX;

   hs_edge_detect u_hs (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .hs      (VGA_HS),
      .hs_fall (hs_fall)
   );

   // Modulo-1024 distance makes sprites straddling row 0 or the frame wrap hit naturally.
   for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
      assign diff[g]    = next_y - SpriteY[g];
      assign hit_vec[g] = SpriteEn[g] && (diff[g] < 10'(SPR_H));
   end

   assign hit         = hit_vec[idx];
   assign last        = (idx == IDX_W'(NUM_SPR-1));
   assign next_y_calc = (DrawY == 10'(V_TOTAL-1)) ? 10'd0 : DrawY + 10'd1;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (hs_fall) state_nxt = SCAN;
         SCAN:   if (hs_fall)   state_nxt = SCAN;
                 else if (hit)  state_nxt = REQ;
                 else if (last) state_nxt = COMMIT;
         REQ:    state_nxt = hs_fall ? SCAN : WAIT;
         WAIT:   if (hs_fall)      state_nxt = rom_ack ? SCAN : DRAIN;
                 else if (rom_ack) state_nxt = last ? COMMIT : SCAN;
         COMMIT: state_nxt = hs_fall ? SCAN : IDLE;
         DRAIN:  if (rom_ack) state_nxt = SCAN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      latch_y   = 1'b0;
      restart   = 1'b0;
      idx_inc   = 1'b0;
      req_load  = 1'b0;
      req_clr   = 1'b0;
      ack_store = 1'b0;
      commit    = 1'b0;
      set_ovr   = 1'b0;
      unique case (state)
         IDLE: begin
            latch_y = hs_fall;
            restart = hs_fall;
         end
         SCAN: begin
            latch_y = hs_fall;
            restart = hs_fall;
            set_ovr = hs_fall;
            idx_inc = !hs_fall && !hit && !last;
         end
         REQ: begin
            latch_y  = hs_fall;
            restart  = hs_fall;
            set_ovr  = hs_fall;
            req_load = !hs_fall;
         end
         WAIT: begin
            req_clr   = rom_ack;
            latch_y   = hs_fall;
            set_ovr   = hs_fall;
            restart   = hs_fall && rom_ack;
            ack_store = !hs_fall && rom_ack;
            idx_inc   = !hs_fall && rom_ack && !last;
         end
         COMMIT: begin
            commit  = 1'b1;
            latch_y = hs_fall;
            restart = hs_fall;
         end
         DRAIN: begin
            req_clr = rom_ack;
            latch_y = hs_fall;
            set_ovr = hs_fall;
            restart = rom_ack;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         idx        <= '0;
         next_y     <= '0;
         shadow     <= '0;
         shadow_vld <= '0;
         rom_req    <= 1'b0;
         rom_addr   <= '0;
         RowMask    <= '0;
         RowValid   <= '0;
         line_ready <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         line_ready <= commit;
         if (commit) begin
            RowMask  <= shadow;
            RowValid <= shadow_vld;
         end
         if (latch_y) next_y <= next_y_calc;
         // Commit reads the old shadow on the same edge a back-to-back line clears it.
         if (restart) begin
            idx        <= '0;
            shadow     <= '0;
            shadow_vld <= '0;
         end else if (idx_inc) begin
            idx <= idx + IDX_W'(1);
         end
         if (ack_store) begin
            shadow[idx]     <= rom_data;
            shadow_vld[idx] <= 1'b1;
         end
         if (req_load) begin
            rom_req  <= 1'b1;
            rom_addr <= pack_rom_addr(SpriteImg[idx], diff[idx][ROW_W-1:0]);
         end else if (req_clr) begin
            rom_req <= 1'b0;
         end
         if (set_ovr) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized bench for sprite_line_scheduler: a latency-programmable ROM
// responder plus a per-line reference model of which rows should be fetched.
module tb_sprite_line_scheduler;

   localparam int N = 4;

   logic                 Clk = 1'b0;
   logic                 Reset_n;
   logic                 VGA_HS;
   logic [9:0]           DrawY;
   logic [N-1:0][9:0]    SpriteX, SpriteY;
   logic [N-1:0]         SpriteEn;
   logic [N-1:0][1:0]    SpriteImg;
   logic                 rom_req;
   logic [6:0]           rom_addr;
   logic                 rom_ack;
   logic [15:0]          rom_data;
   logic [N-1:0][15:0]   RowMask;
   logic [N-1:0]         RowValid;
   logic                 line_ready, overrun;

   int n_chk = 0;
   int n_err = 0;
   int rom_lat = 2;
   int lr_count = 0;

   logic [6:0]         ack_log[$];
   logic [6:0]         exp_addr[$];
   logic [N-1:0][15:0] exp_mask;
   logic [N-1:0]       exp_vld;

   always #5 Clk = ~Clk;

   sprite_line_scheduler dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .VGA_HS     (VGA_HS),
      .DrawY      (DrawY),
      .SpriteX    (SpriteX),
      .SpriteY    (SpriteY),
      .SpriteEn   (SpriteEn),
      .SpriteImg  (SpriteImg),
      .rom_req    (rom_req),
      .rom_addr   (rom_addr),
      .rom_ack    (rom_ack),
      .rom_data   (rom_data),
      .RowMask    (RowMask),
      .RowValid   (RowValid),
      .line_ready (line_ready),
      .overrun    (overrun)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] rom_f(input logic [6:0] a);
      return {a, a[3:0], ~a[4:0]};
   endfunction

   // ROM: acks rom_lat cycles after a request appears, checks the handshake rules.
   initial begin : rom_model
      int cnt;
      bit pending, just_acked;
      logic [6:0] held;
      cnt = 0; pending = 0; just_acked = 0; held = '0;
      rom_ack = 1'b0; rom_data = '0;
      forever begin
         @(negedge Clk);
         rom_ack = 1'b0;
         if (!Reset_n) begin
            pending = 0; cnt = 0; just_acked = 0;
         end else begin
            if (just_acked) chk("req_drop", rom_req, 1'b0);
            if (pending) begin
               chk("req_hold", rom_req, 1'b1);
               chk("addr_stable", rom_addr, held);
            end
            just_acked = 0;
            if (rom_req) begin
               if (!pending) begin pending = 1; held = rom_addr; cnt = 0; end
               cnt++;
               if (cnt >= rom_lat) begin
                  rom_ack = 1'b1;
                  rom_data = rom_f(rom_addr);
                  ack_log.push_back(rom_addr);
                  pending = 0;
                  just_acked = 1;
               end
            end else begin
               pending = 0; cnt = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge Clk);
      if (line_ready === 1'b1) lr_count++;
   end

   // Expected result for a line: every enabled sprite within SPR_H rows of NextY, index order.
   task automatic model(input int dy);
      int ny, d;
      logic [6:0] a;
      ny = (dy == 524) ? 0 : dy + 1;
      exp_addr.delete();
      exp_mask = '0;
      exp_vld = '0;
      for (int i = 0; i < N; i++) begin
         d = (ny - int'(SpriteY[i])) & 1023;
         if (SpriteEn[i] && d < 32) begin
            a = {SpriteImg[i], 5'(d)};
            exp_addr.push_back(a);
            exp_mask[i] = rom_f(a);
            exp_vld[i] = 1'b1;
         end
      end
   endtask

   task automatic hs_pulse(input int dy);
      @(negedge Clk);
      DrawY = 10'(dy);
      VGA_HS = 1'b0;
      repeat (3) @(negedge Clk);
      VGA_HS = 1'b1;
   endtask

   task automatic wait_lr(input int start, input string tag);
      for (int c = 0; c < 600 && lr_count == start; c++) @(negedge Clk);
      repeat (4) @(negedge Clk);
      chk(tag, 64'(lr_count - start), 64'd1);
   endtask

   task automatic wait_req();
      for (int c = 0; c < 50 && rom_req !== 1'b1; c++) @(negedge Clk);
      chk("req_seen", rom_req, 1'b1);
   endtask

   task automatic check_line(input string tag);
      chk($sformatf("%s_vld", tag), RowValid, exp_vld);
      for (int i = 0; i < N; i++) chk($sformatf("%s_mask%0d", tag, i), RowMask[i], exp_mask[i]);
      chk($sformatf("%s_nreq", tag), ack_log.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < ack_log.size(); i++)
         chk($sformatf("%s_addr%0d", tag, i), ack_log[i], exp_addr[i]);
   endtask

   task automatic run_line(input int dy, input string tag);
      int start;
      model(dy);
      ack_log.delete();
      start = lr_count;
      hs_pulse(dy);
      wait_lr(start, {tag, "_lr"});
      check_line(tag);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"}, rom_req, 1'b0);
      chk({tag, "_addr"}, rom_addr, '0);
      chk({tag, "_mask"}, RowMask, '0);
      chk({tag, "_vld"}, RowValid, '0);
      chk({tag, "_lr"}, line_ready, 1'b0);
      chk({tag, "_ovr"}, overrun, 1'b0);
   endtask

   task automatic rand_cfg(input int dy);
      int ny;
      ny = (dy == 524) ? 0 : dy + 1;
      for (int i = 0; i < N; i++) begin
         SpriteEn[i]  = ($urandom_range(0, 3) != 0);
         SpriteImg[i] = 2'($urandom_range(0, 3));
         SpriteX[i]   = 10'($urandom_range(0, 639));
         if ($urandom_range(0, 5) == 0) SpriteY[i] = 10'($urandom_range(0, 1023));
         else SpriteY[i] = 10'((ny - int'($urandom_range(0, 45))) & 1023);
      end
   endtask

   initial begin
      logic [N-1:0][15:0] prev;
      logic [6:0] a0;
      int start;
      Reset_n = 1'b0; VGA_HS = 1'b1; DrawY = '0;
      SpriteX = '0; SpriteY = '0; SpriteEn = '0; SpriteImg = '0;
      repeat (3) @(negedge Clk);
      chk_zero("rst");
      Reset_n = 1'b1;
      repeat (3) @(negedge Clk);

      // Single hit, row 10 of sprite 0
      rom_lat = 2;
      SpriteEn = 4'b0001; SpriteY = {10'd400, 10'd300, 10'd200, 10'd90}; SpriteImg = {2'd0, 2'd0, 2'd0, 2'd2};
      run_line(99, "hit");

      // Frame wrap: NextY = 0, sprite 1 row 0, sprite 2 diff 1019
      SpriteEn = 4'b0110; SpriteY = {10'd0, 10'd5, 10'd0, 10'd0}; SpriteImg = {2'd0, 2'd3, 2'd1, 2'd0};
      run_line(524, "wrap");

      rom_lat = 3;
      SpriteEn = 4'b1111; SpriteY = {10'd70, 10'd80, 10'd95, 10'd100}; SpriteImg = {2'd3, 2'd2, 2'd1, 2'd0};
      run_line(100, "all4");

      SpriteY = {10'd300, 10'd300, 10'd300, 10'd300};
      run_line(100, "nohit");

      // Boundaries at NextY=3: diff 32 miss, 31 hit, sprite above row 0 hit, diff 1023 miss
      rom_lat = 1;
      SpriteY = {10'd4, 10'd1020, 10'd996, 10'd995};
      run_line(2, "edge");

      for (int k = 0; k < 40; k++) begin
         int dy;
         rom_lat = $urandom_range(1, 4);
         dy = ($urandom_range(0, 7) == 0) ? 524 : int'($urandom_range(0, 524));
         rand_cfg(dy);
         run_line(dy, $sformatf("rnd%0d", k));
      end
      chk("ovr_clear", overrun, 1'b0);

      // HS edge while the ROM is still answering: old fetch drained and discarded
      SpriteEn = 4'b0001; SpriteY = {10'd0, 10'd0, 10'd0, 10'd100}; SpriteImg = {2'd0, 2'd0, 2'd0, 2'd3};
      model(100);
      a0 = exp_addr[0];
      model(110);
      prev = RowMask;
      ack_log.delete();
      start = lr_count;
      rom_lat = 20;
      hs_pulse(100);
      wait_req();
      hs_pulse(110);
      chk("ovr_set", overrun, 1'b1);
      chk("ovr_hold_mask", RowMask, prev);
      wait_lr(start, "ovr_lr");
      chk("ovr_nacks", ack_log.size(), 2);
      if (ack_log.size() > 0) begin
         chk("ovr_drain_addr", ack_log[0], a0);
         void'(ack_log.pop_front());
      end
      check_line("ovr");
      chk("ovr_sticky", overrun, 1'b1);

      // Reset in the middle of a fetch, off any clock edge
      ack_log.delete();
      hs_pulse(100);
      wait_req();
      #3 Reset_n = 1'b0;
      #1 chk_zero("async_rst");
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      rom_lat = 2;
      repeat (2) @(negedge Clk);
      run_line(100, "post_rst");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
